// File: rtl/fir_sample_feeder.sv
// Sample feeder for a FIR core: buffers upstream samples and streams L data strobes, then N-1 zero strobes.
// Latency: 2 cycles from an upstream handshake to the matching o_ce; o_done follows the last strobe by 1 cycle.
// Backpressure: o_s_ready drops when the FIFO is full or L samples are taken; i_hold stalls all strobes.
module fir_sample_feeder #(
    parameter int IW    = 12,
    parameter int DEPTH = 8
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_start,
    input  logic          i_clear,
    input  logic [15:0]   i_output_length,
    input  logic [3:0]    i_ntaps,
    input  logic          i_hold,
    input  logic          i_s_valid,
    input  logic [IW-1:0] i_s_data,
    output logic          o_s_ready,
    output logic          o_ce,
    output logic [IW-1:0] o_sample,
    output logic          o_busy,
    output logic          o_done,
    output logic [15:0]   o_sample_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;

    logic [IW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;

    logic [15:0]   r_len;
    logic [3:0]    r_ntaps;
    logic [15:0]   r_accepted;
    logic [15:0]   r_popped;
    logic [3:0]    r_flush_left;
    logic          r_ce;
    logic [IW-1:0] r_sample;
    logic          r_done;
    logic [15:0]   r_count;

    logic          w_empty;
    logic          w_full;
    logic          w_s_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_flush_stb;
    logic          w_last_pop;
    logic          w_last_flush;
    logic [3:0]    w_ntaps_in;
    logic [3:0]    w_nt_eff;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = ((r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}});
    // Ready looks only at the registered full flag; a pop in the same cycle never makes room.
    assign w_s_ready    = (r_state == S_STREAM) && !w_full && (r_accepted < r_len);
    assign w_push       = i_s_valid && w_s_ready && !i_clear;
    assign w_pop        = (r_state == S_STREAM) && !w_empty && !i_hold && !i_clear;
    assign w_flush_stb  = (r_state == S_FLUSH) && !i_hold && !i_clear;
    assign w_last_pop   = w_pop && (r_popped == r_len - 16'd1);
    assign w_last_flush = w_flush_stb && (r_flush_left == 4'd1);
    // A tap count of zero behaves as a single tap (no flush zeros).
    assign w_ntaps_in   = (i_ntaps == 4'd0) ? 4'd1 : i_ntaps;
    assign w_nt_eff     = (r_state == S_IDLE) ? w_ntaps_in : r_ntaps;

    assign o_s_ready      = w_s_ready;
    assign o_ce           = r_ce;
    assign o_sample       = r_sample;
    assign o_busy         = (r_state == S_STREAM) || (r_state == S_FLUSH);
    assign o_done         = r_done;
    assign o_sample_count = r_count;

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; clear overrides every other transition.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_output_length != 16'd0) begin
                        w_next = S_STREAM;
                    end else if (w_ntaps_in > 4'd1) begin
                        w_next = S_FLUSH;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_STREAM: begin
                if (w_last_pop) begin
                    w_next = (r_ntaps > 4'd1) ? S_FLUSH : S_DONE;
                end
            end
            S_FLUSH: begin
                if (w_last_flush) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_clear) begin
            w_next = S_IDLE;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_s_data;
        end
    end

    // Frame bookkeeping, FIFO pointers and the registered strobe/sample/done outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_len        <= '0;
            r_ntaps      <= '0;
            r_accepted   <= '0;
            r_popped     <= '0;
            r_flush_left <= '0;
            r_ce         <= 1'b0;
            r_sample     <= '0;
            r_done       <= 1'b0;
            r_count      <= '0;
        end else begin
            r_ce   <= 1'b0;
            r_done <= 1'b0;
            if (i_clear) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if ((r_state == S_IDLE) && i_start) begin
                    r_len      <= i_output_length;
                    r_ntaps    <= w_ntaps_in;
                    r_count    <= '0;
                    r_accepted <= '0;
                    r_popped   <= '0;
                end
                if (w_push) begin
                    r_wr_ptr   <= r_wr_ptr + (AW+1)'(1);
                    r_accepted <= r_accepted + 16'd1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
                    r_popped <= r_popped + 16'd1;
                    r_ce     <= 1'b1;
                    r_sample <= r_mem[r_rd_ptr[AW-1:0]];
                    r_count  <= r_count + 16'd1;
                end
                // Outside FLUSH the down-counter is preloaded with N-1 so it is ready on entry.
                if (w_flush_stb) begin
                    r_ce         <= 1'b1;
                    r_sample     <= '0;
                    r_count      <= r_count + 16'd1;
                    r_flush_left <= r_flush_left - 4'd1;
                end else if (r_state != S_FLUSH) begin
                    r_flush_left <= w_nt_eff - 4'd1;
                end
                if (r_state == S_DONE) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule
